// File: rtl/huffman_encoder_if.sv
// Symbol-in / serial-code-out bundle for huffman_encoder.
// master drives symbols; slave is the encoder.
interface huffman_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [2:0]    sym;
  logic          sym_valid;
  logic          sym_ready;
  logic          bit_out;
  logic          bit_valid;
  logic          code_end;
  logic          err;
  logic [LW-1:0] fifo_level;

  modport master (
    output sym,
    output sym_valid,
    input  sym_ready,
    input  bit_out,
    input  bit_valid,
    input  code_end,
    input  err,
    input  fifo_level
  );

  modport slave (
    input  sym,
    input  sym_valid,
    output sym_ready,
    output bit_out,
    output bit_valid,
    output code_end,
    output err,
    output fifo_level
  );
endinterface

// File: rtl/huffman_encoder.sv
// Huffman encoder: symbol FIFO feeding a serial MSB-first code shifter.
// Codewords are the inverse of huffman_decoder's table.
module huffman_encoder #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  huffman_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic [3:0]    code;
  logic [2:0]    rem;
  logic          bit_q;
  logic          valid_q;
  logic          end_q;
  logic          err_q;

  logic [2:0]    head;
  logic [3:0]    hcode;
  logic [2:0]    hlen;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;

  assign bus.sym_ready  = level < LW'(DEPTH);
  assign bus.bit_out    = bit_q;
  assign bus.bit_valid  = valid_q;
  assign bus.code_end   = end_q;
  assign bus.err        = err_q;
  assign bus.fifo_level = level;

  assign accept = bus.sym_valid && bus.sym_ready;
  assign legal  = (bus.sym != 3'd0) && (bus.sym != 3'd7);
  assign push   = accept && legal;
  // rem==0 in SHIFT means the last bit is on the wire now
  assign pop    = (level != '0) &&
                  ((state == IDLE) || (rem == 3'd0));
  assign head   = mem[rd_ptr];

  always_comb begin
    hcode = 4'b0000;
    hlen  = 3'd1;
    case (head)
      3'd1: begin
        hcode = 4'b0000;
        hlen  = 3'd1;
      end
      3'd2: begin
        hcode = 4'b1010;
        hlen  = 3'd3;
      end
      3'd3: begin
        hcode = 4'b1000;
        hlen  = 3'd3;
      end
      3'd4: begin
        hcode = 4'b1110;
        hlen  = 3'd3;
      end
      3'd5: begin
        hcode = 4'b1101;
        hlen  = 3'd4;
      end
      3'd6: begin
        hcode = 4'b1100;
        hlen  = 3'd4;
      end
      default: begin
        hcode = 4'b0000;
        hlen  = 3'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.sym;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      code    <= '0;
      rem     <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
    end else if (pop) begin
      state   <= SHIFT;
      bit_q   <= hcode[3];
      code    <= {hcode[2:0], 1'b0};
      rem     <= hlen - 3'd1;
      valid_q <= 1'b1;
      end_q   <= (hlen == 3'd1);
    end else if ((state == SHIFT) && (rem != 3'd0)) begin
      bit_q   <= code[3];
      code    <= {code[2:0], 1'b0};
      rem     <= rem - 3'd1;
      valid_q <= 1'b1;
      end_q   <= (rem == 3'd1);
    end else begin
      state   <= IDLE;
      code    <= '0;
      rem     <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
    end
  end
endmodule

// File: doc/huffman_encoder.md
HUFFMAN_ENCODER -- requirements
Module: huffman_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, symbol FIFO depth; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit, clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-004 SHALL have port sym, input, 3 bits, symbol to encode; legal values are 1..6.
REQ-005 SHALL have port sym_valid, input, 1 bit, sym is presented this cycle.
REQ-006 SHALL have port sym_ready, output, 1 bit, the FIFO can accept a symbol this cycle.
REQ-007 SHALL have port bit_out, output, 1 bit, serial code bit, sent MSB-first; it feeds huffman_decoder input x.
REQ-008 SHALL have port bit_valid, output, 1 bit, bit_out carries a code bit this cycle.
REQ-009 SHALL have port code_end, output, 1 bit, marks the last bit of a codeword.
REQ-010 SHALL have port err, output, 1 bit, one-cycle pulse on acceptance of an illegal symbol.
REQ-011 SHALL have port fifo_level, output, clog2(DEPTH)+1 bits, number of symbols stored.

Function
REQ-012 SHALL use this code table, MSB first: 1="0", 2="101", 3="100", 4="111", 5="1101", 6="1100".
- This table is the exact inverse of huffman_decoder.
REQ-013 SHALL accept a symbol on a clock edge where sym_valid=1 and sym_ready=1, and ignore sym at all other edges.
REQ-014 SHALL drive sym_ready = (fifo_level < DEPTH), derived from registered state only.
- There is no bypass.
- When the FIFO is full, a pop in the same cycle does not enable a push.
REQ-015 SHALL write each accepted legal symbol into the FIFO tail; fifo_level increments by 1 unless a pop occurs on the same edge.
REQ-016 SHALL treat accepted symbols 0 and 7 as illegal.
- The symbol is not written and fifo_level is unchanged.
- err=1 for exactly the one cycle following the accepting edge.
REQ-017 SHALL contain a shifter with states IDLE and SHIFT, plus a code register and a remaining-bit counter.
REQ-018 In IDLE with fifo_level>0, SHALL on the next edge:
- pop the FIFO head;
- load its codeword;
- enter SHIFT;
- register the codeword MSB onto bit_out with bit_valid=1.
REQ-019 In SHIFT, SHALL present one bit per cycle in MSB-first order, with bit_valid=1 on every bit of the codeword.
REQ-020 SHALL assert code_end=1 together with the final bit of each codeword, and 0 otherwise.
REQ-021 On the edge that ends the final bit:
- with fifo_level>0, SHALL pop and load the next codeword so its MSB follows with no idle cycle;
- otherwise SHALL return to IDLE with bit_valid=0.
REQ-022 SHALL hold bit_out=0, bit_valid=0 and code_end=0 whenever no code bit is presented.
REQ-023 Latency: a legal symbol accepted at edge E into an empty FIFO with the shifter in IDLE SHALL have its first bit valid from edge E+1.
REQ-024 On a simultaneous push and pop, SHALL leave fifo_level unchanged and keep FIFO order strictly first-in first-out.
REQ-025 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-026 SHALL never pop an empty FIFO, and SHALL never overwrite an unread entry.
REQ-027 SHALL make all outputs except sym_ready registered.

Reset
REQ-028 When reset=1, SHALL immediately, asynchronously:
- clear the FIFO pointers and set fifo_level=0;
- set the shifter to IDLE;
- set bit_out=0, bit_valid=0, code_end=0, err=0.
REQ-029 When reset=1 mid-codeword, SHALL discard the partial codeword and all queued symbols; no residual bits appear after reset is released.
REQ-030 When reset=1, SHALL drive sym_ready=1; no symbol is accepted while reset=1.

Verification
REQ-031 Reset, then push sym=5 once -> bit_valid=1 for 4 cycles with bits 1,1,0,1; code_end on the 4th bit; bit_valid=0 afterwards.
REQ-032 Push 1,4,3 on consecutive cycles -> continuous bits 0,1,1,1,1,0,0 with no gap; code_end on bits 1, 4 and 7.
REQ-033 Push sym=7, then sym=0 -> err pulses once per push; no bits emitted; fifo_level stays 0.
REQ-034 DEPTH=4, hold sym_valid=1 with sym=6 for 12 cycles:
- fifo_level reaches 4 and sym_ready=0 at that point;
- sym_ready recovers as entries are popped;
- the number of accepted symbols equals the number of "1100" codewords emitted.
REQ-035 Assert reset during the 2nd bit of a sym=5 codeword with 2 symbols queued -> bit_valid=0 and fifo_level=0 immediately; no bits after release.
REQ-036 Loopback bit_out into huffman_decoder x, push the repeating sequence 1..6 with no gaps -> the decoder emits the same symbol sequence in order.
